// File: rtl/hazard_tracker_pkg.sv
// Shared constants, forwarding encodings and the pipeline slot record for hazard_tracker.
package hazard_tracker_pkg;

  localparam int REG_W  = 5;
  localparam int TNEW_W = 3;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic              regw;
    logic [TNEW_W-1:0] tnew;
  } slot_t;

  // M is checked first so the youngest ready producer wins; $0 never forwards.
  function automatic fwd_sel_e fwd_pick(input logic [REG_W-1:0] src,
                                        input slot_t m, input slot_t w);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (src != '0) begin
      if (m.regw && m.dst == src && m.tnew == '0)
        sel = FWD_M;
      else if (w.regw && w.dst == src && w.tnew == '0)
        sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// Decode-side request, E-stage sources and tracked per-stage state of hazard_tracker.
interface hazard_tracker_if;
  import hazard_tracker_pkg::*;

  logic [REG_W-1:0]  dst_D;
  logic              regw_D;
  logic [TNEW_W-1:0] tnew_D;
  logic              stall;
  logic [REG_W-1:0]  rsE;
  logic [REG_W-1:0]  rtE;

  logic [REG_W-1:0]  rt_rdE, rt_rdM, rt_rdW;
  logic              regwE, regwM, regwW;
  logic [TNEW_W-1:0] T_new_E, T_new_M, T_new_W;
  logic [1:0]        fwd_rs_sel, fwd_rt_sel;

  modport master (
    output dst_D, regw_D, tnew_D, stall, rsE, rtE,
    input  rt_rdE, rt_rdM, rt_rdW, regwE, regwM, regwW,
           T_new_E, T_new_M, T_new_W, fwd_rs_sel, fwd_rt_sel
  );

  modport slave (
    input  dst_D, regw_D, tnew_D, stall, rsE, rtE,
    output rt_rdE, rt_rdM, rt_rdW, regwE, regwM, regwW,
           T_new_E, T_new_M, T_new_W, fwd_rs_sel, fwd_rt_sel
  );
endinterface

// File: rtl/hazard_slot.sv
// One pipeline slot {dst, regw, tnew} with async reset and optional saturating tnew decrement.
module hazard_slot
  import hazard_tracker_pkg::*;
#(
  parameter bit DEC = 1'b0
) (
  input  logic  clk,
  input  logic  reset,
  input  slot_t d,
  output slot_t q
);

  slot_t r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r <= '0;
    end else begin
      r.dst  <= d.dst;
      r.regw <= d.regw;
      if (DEC && d.tnew != '0)
        r.tnew <= d.tnew - TNEW_W'(1);
      else
        r.tnew <= d.tnew;
    end
  end

  // Writes to $0 are stored as-is but never advertised as a pending write.
  assign q.dst  = r.dst;
  assign q.regw = r.regw & (r.dst != '0);
  assign q.tnew = r.tnew;

endmodule

// File: rtl/hazard_tracker.sv
// Tracks destination/write/ready-time through E, M, W and selects E-stage operand forwarding.
module hazard_tracker
  import hazard_tracker_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  hazard_tracker_if.slave  bus
);

  slot_t e_in, e_q, m_q, w_q;

  // A stall injects a bubble into E; M and W always advance.
  always_comb begin
    e_in = '0;
    if (!bus.stall) begin
      e_in.dst  = bus.dst_D;
      e_in.regw = bus.regw_D;
      e_in.tnew = bus.tnew_D;
    end
  end

  hazard_slot #(.DEC(1'b0)) u_slot_e (.clk(clk), .reset(reset), .d(e_in), .q(e_q));
  hazard_slot #(.DEC(1'b1)) u_slot_m (.clk(clk), .reset(reset), .d(e_q),  .q(m_q));
  hazard_slot #(.DEC(1'b1)) u_slot_w (.clk(clk), .reset(reset), .d(m_q),  .q(w_q));

  assign bus.rt_rdE  = e_q.dst;
  assign bus.regwE   = e_q.regw;
  assign bus.T_new_E = e_q.tnew;
  assign bus.rt_rdM  = m_q.dst;
  assign bus.regwM   = m_q.regw;
  assign bus.T_new_M = m_q.tnew;
  assign bus.rt_rdW  = w_q.dst;
  assign bus.regwW   = w_q.regw;
  assign bus.T_new_W = w_q.tnew;

  always_comb begin
    bus.fwd_rs_sel = fwd_pick(bus.rsE, m_q, w_q);
    bus.fwd_rt_sel = fwd_pick(bus.rtE, m_q, w_q);
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed vector bench for hazard_tracker: stage tracking, forwarding priority, async reset.
module tb_hazard_tracker;
  import hazard_tracker_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  hazard_tracker_if bus ();

  hazard_tracker dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic [4:0] dst;
    logic       regw;
    logic [2:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    slot_t      e, m, w;
    logic [1:0] frs, frt;
  } vec_t;

  vec_t vecs[16];
  int checks = 0;
  int errors = 0;

  function automatic slot_t s(input int d, input int r, input int t);
    slot_t x;
    x.dst = 5'(d); x.regw = 1'(r); x.tnew = 3'(t);
    return x;
  endfunction

  function automatic vec_t v(input int st, input int d, input int r, input int t,
                             input int rs, input int rt, input slot_t e, input slot_t m,
                             input slot_t w, input int frs, input int frt);
    vec_t x;
    x.stall = 1'(st); x.dst = 5'(d); x.regw = 1'(r); x.tnew = 3'(t);
    x.rs = 5'(rs); x.rt = 5'(rt); x.e = e; x.m = m; x.w = w;
    x.frs = 2'(frs); x.frt = 2'(frt);
    return x;
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input slot_t e, input slot_t m, input slot_t w,
                         input logic [1:0] frs, input logic [1:0] frt);
    chk({tag, " E"}, {bus.rt_rdE, bus.regwE, bus.T_new_E}, e);
    chk({tag, " M"}, {bus.rt_rdM, bus.regwM, bus.T_new_M}, m);
    chk({tag, " W"}, {bus.rt_rdW, bus.regwW, bus.T_new_W}, w);
    chk({tag, " fwd_rs"}, {7'd0, bus.fwd_rs_sel}, {7'd0, frs});
    chk({tag, " fwd_rt"}, {7'd0, bus.fwd_rt_sel}, {7'd0, frt});
  endtask

  task automatic drive(input logic st, input int d, input int r, input int t,
                       input int rs, input int rt);
    bus.stall = st; bus.dst_D = 5'(d); bus.regw_D = 1'(r); bus.tnew_D = 3'(t);
    bus.rsE = 5'(rs); bus.rtE = 5'(rt);
  endtask

  initial begin
    slot_t z;
    z = s(0, 0, 0);
    //          st dst rw tn rs rt   E            M            W           frs frt
    vecs[0]  = v(0, 5, 1, 2, 0, 0, s(5,1,2), z,        z,        0, 0);
    vecs[1]  = v(0, 0, 0, 0, 5, 0, z,        s(5,1,1), z,        0, 0);
    vecs[2]  = v(0, 0, 0, 0, 5, 5, z,        z,        s(5,1,0), 2, 2);
    vecs[3]  = v(0, 3, 1, 5, 0, 0, s(3,1,5), z,        z,        0, 0);
    vecs[4]  = v(1, 7, 1, 1, 3, 0, z,        s(3,1,4), z,        0, 0);
    vecs[5]  = v(0, 8, 1, 1, 3, 0, s(8,1,1), z,        s(3,1,3), 0, 0);
    vecs[6]  = v(0, 8, 1, 1, 8, 8, s(8,1,1), s(8,1,0), z,        1, 1);
    vecs[7]  = v(0, 0, 0, 0, 8, 0, z,        s(8,1,0), s(8,1,0), 1, 0);
    vecs[8]  = v(0, 0, 0, 0, 8, 0, z,        z,        s(8,1,0), 2, 0);
    vecs[9]  = v(0, 0, 1, 1, 0, 0, s(0,0,1), z,        z,        0, 0);
    vecs[10] = v(0, 9, 1, 2, 0, 9, s(9,1,2), s(0,0,0), z,        0, 0);
    vecs[11] = v(0, 0, 0, 0, 0, 9, z,        s(9,1,1), s(0,0,0), 0, 0);
    vecs[12] = v(0, 0, 0, 0, 0, 9, z,        z,        s(9,1,0), 0, 2);
    vecs[13] = v(0, 6, 1, 1, 0, 6, s(6,1,1), z,        z,        0, 0);
    vecs[14] = v(0, 0, 0, 0, 6, 0, z,        s(6,1,0), z,        1, 0);
    vecs[15] = v(0, 0, 0, 0, 0, 6, z,        z,        s(6,1,0), 0, 2);

    drive(0, 4, 1, 1, 4, 4);
    #2;
    chk_all("reset_hold", z, z, z, 2'd0, 2'd0);
    @(posedge clk); #1;
    chk_all("reset_edge", z, z, z, 2'd0, 2'd0);

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].stall, int'(vecs[i].dst), int'(vecs[i].regw), int'(vecs[i].tnew),
            int'(vecs[i].rs), int'(vecs[i].rt));
      @(posedge clk); #1;
      chk_all($sformatf("vec%0d", i), vecs[i].e, vecs[i].m, vecs[i].w,
              vecs[i].frs, vecs[i].frt);
      @(negedge clk);
    end

    // Fill all three slots with ready producers, then reset between edges.
    drive(0, 10, 1, 0, 0, 0); @(posedge clk); @(negedge clk);
    drive(0, 11, 1, 1, 0, 0); @(posedge clk); @(negedge clk);
    drive(0, 12, 1, 2, 11, 10); @(posedge clk); #1;
    chk_all("full", s(12,1,2), s(11,1,0), s(10,1,0), 2'd1, 2'd2);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", z, z, z, 2'd0, 2'd0);
    @(posedge clk); #1;
    chk_all("rst_held", z, z, z, 2'd0, 2'd0);

    @(negedge clk);
    reset = 1'b0;
    drive(0, 13, 1, 1, 0, 0);
    @(posedge clk); #1;
    chk_all("post_rst", s(13,1,1), z, z, 2'd0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset; all other ports follow.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 dst_D  input  5  destination register of the instruction leaving D.
REQ-005 regw_D  input  1  the instruction leaving D writes the register file.
REQ-006 tnew_D  input  3  cycles from E entry until the result exists (ALU=1, load=2, none=0).
REQ-007 stall  input  1  hazard stall this cycle; D is held and a bubble enters E.
REQ-008 rsE, rtE  input  5 each  source registers of the instruction currently in E.
REQ-009 rt_rdE, rt_rdM, rt_rdW  output  5 each  tracked destination per stage.
REQ-010 regwE, regwM, regwW  output  1 each  tracked write-enable per stage.
REQ-011 T_new_E, T_new_M, T_new_W  output  3 each  remaining cycles until the stage result is ready.
REQ-012 fwd_rs_sel, fwd_rt_sel  output  2 each  E-stage forwarding select: 0 = register file, 1 = from M, 2 = from W.

Function
REQ-013 The E, M and W slots SHALL each hold {dst, regw, tnew} in registers updated on every rising clk edge; there is no global enable.
REQ-014 When stall=0, the E slot SHALL load {dst_D, regw_D, tnew_D}.
REQ-015 When stall=1, the E slot SHALL load a bubble {0, 0, 0}.
REQ-016 The M slot SHALL load the E slot with tnew = max(T_new_E-1, 0), regardless of stall.
REQ-017 The W slot SHALL load the M slot with tnew = max(T_new_M-1, 0), regardless of stall.
REQ-018 A slot with dst=0 SHALL force its regw output to 0, so writes to $0 never appear as hazards.
REQ-019 The decrement SHALL saturate at 0; tnew values above 2 SHALL be accepted, and the excess SHALL drain one per stage.
REQ-020 Stage outputs SHALL be driven combinationally from the slot registers, with zero added latency.
REQ-021 fwd_rs_sel SHALL be 1 when rsE!=0, regwM=1, rt_rdM=rsE and T_new_M=0.
REQ-022 Otherwise, fwd_rs_sel SHALL be 2 when rsE!=0, regwW=1, rt_rdW=rsE and T_new_W=0.
REQ-023 Otherwise, fwd_rs_sel SHALL be 0; fwd_rt_sel SHALL follow the same rules using rtE.
REQ-024 When M and W both match, M SHALL win (youngest producer has priority).
REQ-025 A matching producer with tnew>0 SHALL NOT be forwarded; the stall unit is responsible for that case.
REQ-026 Encoding 3 of the select outputs SHALL never be produced.

Reset
REQ-027 Reset assertion SHALL immediately clear every slot to {0, 0, 0}, without waiting for clk.
REQ-028 While reset is held, all outputs SHALL be 0, including both select outputs.
REQ-029 Reset asserted mid-pipeline SHALL discard all in-flight entries.
REQ-030 On the first edge after reset deassertion, the E slot SHALL load normally per REQ-014/015.

Structure
REQ-031 A shared package SHALL hold the REG_W=5 and TNEW_W=3 constants, the FWD_RF/FWD_M/FWD_W encodings, and a slot struct type {dst, regw, tnew}.
REQ-032 The block SHALL use one sub-module, hazard_slot (a single-slot register with async reset and a saturating-decrement option), instantiated three times.
REQ-033 The forwarding-select logic SHALL remain combinational in the top module.

Verification
REQ-034 Load chain: lw $5 (dst=5, regw=1, tnew=2), stall=0, then bubbles -> E={5,1,2}, next cycle M={5,1,1}, next cycle W={5,1,0}.
REQ-035 Stall bubble: stall=1 with dst_D=7, regw_D=1, tnew_D=1 -> after the edge E={0,0,0} while M receives the previous E contents.
REQ-036 Forward priority: M={8,1,0}, W={8,1,0}, rsE=8 -> fwd_rs_sel=1; clear M -> fwd_rs_sel=2.
REQ-037 Not ready: M={9,1,1}, rtE=9 -> fwd_rt_sel=0; after one edge, W={9,1,0} -> fwd_rt_sel=2.
REQ-038 Zero register: dst_D=0, regw_D=1 -> regwE=0, and rsE=0 always yields fwd_rs_sel=0.
REQ-039 Async reset: assert reset between edges while all slots are full -> all outputs 0 before the next clk edge.
